// File: rtl/sspis_ctl.sv
// SPI responder: oversamples SCK/SS_N/MOSI in clk, assembles 1-4 byte RX words, serves MISO; no backpressure.
// Latency: rx_valid rises SYNC_STAGES+2 clk after the final sampling SCK pin edge.
module sspis_ctl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_cpol,
    input  logic        cfg_cpha,
    input  logic        cfg_endian,
    input  logic [1:0]  cfg_transfer_size,
    input  logic [31:0] cfg_datain,
    output logic [31:0] cfg_dataout,
    output logic        rx_valid,
    output logic        op_done,
    output logic        frame_err,
    output logic        busy,
    input  logic        sspis_sck,
    input  logic        sspis_ssn,
    input  logic        sspis_mosi,
    output logic        sspis_miso,
    output logic        sspis_miso_oen
);

    typedef enum logic [1:0] {IDLE, DATA, DONE, WAIT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync, seen;
    logic        sck_d, ssn_d, armed_q;
    logic        cpol_q, cpha_q, endian_q;
    logic [1:0]  size_q, byte_cnt;
    logic [2:0]  bit_cnt;
    logic [31:0] tx_q, rx_word;
    logic [6:0]  rx_shift;

    function automatic logic [4:0] slice_base(input logic [1:0] idx, input logic big);
        logic [1:0] s;
        s = big ? ~idx : idx;
        return {s, 3'b000};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= {SYNC_STAGES{cfg_cpol}};
            ssn_sync  <= '1;
            mosi_sync <= '0;
            seen      <= '0;
            sck_d     <= cfg_cpol;
            ssn_d     <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sspis_sck};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], sspis_ssn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], sspis_mosi};
            seen      <= {seen[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ssn_d     <= ssn_sync[SYNC_STAGES-1];
            // A frame may only start after SS_N has been genuinely seen high since reset
            armed_q   <= armed_q | (seen[SYNC_STAGES-1] & ssn_sync[SYNC_STAGES-1]);
        end
    end

    logic sck_s, ssn_s, mosi_s;
    logic sck_rise, sck_fall, ssn_fall, ssn_rise;
    logic lead_edge, trail_edge, sample_edge, shift_edge, last_bit, byte_last;
    logic [7:0] tx_byte;

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ssn_s       = ssn_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign ssn_fall    = armed_q & ~ssn_s & ssn_d;
    assign ssn_rise    = ssn_s & ~ssn_d;
    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign last_bit    = sample_edge && (bit_cnt == 3'd7);
    assign byte_last   = (byte_cnt == size_q);
    assign tx_byte     = tx_q[slice_base(byte_cnt, endian_q) +: 8];
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ssn_fall) state_d = DATA;
            DATA: begin
                if (ssn_rise)                    state_d = IDLE;
                else if (last_bit && byte_last)  state_d = DONE;
            end
            DONE: state_d = WAIT;
            WAIT: if (ssn_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cfg_dataout    <= '0;
            rx_valid       <= 1'b0;
            op_done        <= 1'b0;
            frame_err      <= 1'b0;
            sspis_miso     <= 1'b0;
            sspis_miso_oen <= 1'b1;
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            endian_q       <= 1'b0;
            size_q         <= '0;
            tx_q           <= '0;
            rx_word        <= '0;
            rx_shift       <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
        end else begin
            state_q   <= state_d;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    op_done        <= 1'b0;
                    sspis_miso_oen <= 1'b1;
                    if (ssn_fall) begin
                        cpol_q         <= cfg_cpol;
                        cpha_q         <= cfg_cpha;
                        endian_q       <= cfg_endian;
                        size_q         <= cfg_transfer_size;
                        tx_q           <= cfg_datain;
                        rx_word        <= '0;
                        bit_cnt        <= '0;
                        byte_cnt       <= '0;
                        sspis_miso_oen <= 1'b0;
                        // Mode with leading-edge sampling needs bit 7 ready before the first SCK edge
                        sspis_miso     <= cfg_cpha ? 1'b0
                                        : (cfg_endian ? cfg_datain[31] : cfg_datain[7]);
                    end
                end
                DATA: begin
                    if (ssn_rise) begin
                        frame_err      <= 1'b1;
                        sspis_miso_oen <= 1'b1;
                        sspis_miso     <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            rx_word[slice_base(byte_cnt, endian_q) +: 8] <= {rx_shift, mosi_s};
                            if (byte_last) sspis_miso <= 1'b0;
                            else           byte_cnt   <= byte_cnt + 2'd1;
                        end
                    end else if (shift_edge) begin
                        sspis_miso <= tx_byte[~bit_cnt];
                    end
                end
                DONE: begin
                    cfg_dataout <= rx_word;
                    rx_valid    <= 1'b1;
                    op_done     <= 1'b1;
                    sspis_miso  <= 1'b0;
                end
                WAIT: begin
                    sspis_miso <= 1'b0;
                    if (ssn_s) begin
                        op_done        <= 1'b0;
                        sspis_miso_oen <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sspis_ctl.sv
// Directed SPI master driving sspis_ctl; expected RX words go through a scoreboard queue checked on rx_valid.
module tb_sspis_ctl;

    localparam int H = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_cpol, cfg_cpha, cfg_endian;
    logic [1:0]  cfg_transfer_size;
    logic [31:0] cfg_datain, cfg_dataout;
    logic        rx_valid, op_done, frame_err, busy;
    logic        sspis_sck, sspis_ssn, sspis_mosi, sspis_miso, sspis_miso_oen;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_seen = 0;
    time         t_last = 0;

    sspis_ctl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_endian(cfg_endian),
        .cfg_transfer_size(cfg_transfer_size), .cfg_datain(cfg_datain),
        .cfg_dataout(cfg_dataout), .rx_valid(rx_valid), .op_done(op_done),
        .frame_err(frame_err), .busy(busy),
        .sspis_sck(sspis_sck), .sspis_ssn(sspis_ssn), .sspis_mosi(sspis_mosi),
        .sspis_miso(sspis_miso), .sspis_miso_oen(sspis_miso_oen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && frame_err) err_seen++;
        if (!reset && rx_valid) begin
            if (exp_q.size() == 0) begin
                chk("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("dataout", cfg_dataout, exp_q.pop_front());
                chk("rx_latency_clk", 32'(($time - t_last) / 10), 32'd4);
            end
        end
    end

    // mo / mi_exp hold byte 0 in [31:24], byte 1 in [23:16], ...
    task automatic frame(input logic cpol, input logic cpha, input logic endian,
                         input logic [1:0] size, input logic [31:0] din,
                         input logic [31:0] mo, input logic [31:0] mi_exp,
                         input logic [31:0] dout_exp, input int nbits,
                         input bit change_mid, input int extra);
        logic [7:0] got;
        bit         complete;
        int         errs0;
        complete          = (nbits == 8 * (int'(size) + 1));
        errs0             = err_seen;
        cfg_cpol          = cpol;
        cfg_cpha          = cpha;
        cfg_endian        = endian;
        cfg_transfer_size = size;
        cfg_datain        = din;
        sspis_sck         = cpol;
        sspis_mosi        = 1'b0;
        #100;
        if (complete) exp_q.push_back(dout_exp);
        got       = '0;
        sspis_ssn = 1'b0;
        if (!cpha) sspis_mosi = mo[31];
        #H;
        for (int i = 0; i < nbits; i++) begin
            if (change_mid && i == 4) begin
                cfg_datain = ~din;
                cfg_endian = ~endian;
            end
            if (cpha) begin
                sspis_sck  = ~sspis_sck;
                sspis_mosi = mo[31-i];
                #H;
            end
            sspis_sck = ~sspis_sck;
            got       = {got[6:0], sspis_miso};
            t_last    = $time;
            if (i % 8 == 7) chk("miso_byte", {24'd0, got}, {24'd0, mi_exp[31-8*(i/8) -: 8]});
            // Invert MOSI shortly after the sample edge so a wrong-edge sampler sees garbage
            #20 sspis_mosi = ~sspis_mosi;
            #(H-20);
            if (!cpha) begin
                sspis_sck = ~sspis_sck;
                if (i + 1 < nbits) sspis_mosi = mo[30-i];
                #H;
            end
        end
        for (int k = 0; k < extra; k++) begin
            sspis_sck = ~sspis_sck;
            #H;
            chk("miso_after_done", {31'd0, sspis_miso}, 32'd0);
            sspis_sck = ~sspis_sck;
            #H;
        end
        #H;
        if (complete) begin
            chk("op_done_high", {31'd0, op_done}, 32'd1);
            chk("rx_received", exp_q.size(), 32'd0);
        end
        sspis_ssn = 1'b1;
        #100;
        chk("op_done_low", {31'd0, op_done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("miso_oen_idle", {31'd0, sspis_miso_oen}, 32'd1);
        chk("frame_err_count", err_seen - errs0, complete ? 32'd0 : 32'd1);
        if (!complete) chk("dataout_kept", cfg_dataout, dout_exp);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dataout", cfg_dataout, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_op_done", {31'd0, op_done}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, sspis_miso}, 32'd0);
        chk("rst_miso_oen", {31'd0, sspis_miso_oen}, 32'd1);
    endtask

    initial begin
        reset             = 1'b1;
        cfg_cpol          = 1'b0;
        cfg_cpha          = 1'b0;
        cfg_endian        = 1'b0;
        cfg_transfer_size = 2'd0;
        cfg_datain        = '0;
        sspis_sck         = 1'b0;
        sspis_ssn         = 1'b1;
        sspis_mosi        = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
        #100;

        // Mode 0, little endian, 4 bytes
        frame(1'b0, 1'b0, 1'b0, 2'd3, 32'hA1B2C3D4, 32'h11223344, 32'hD4C3B2A1,
              32'h44332211, 32, 1'b0, 0);
        // Mode 3, big endian, 2 bytes
        frame(1'b1, 1'b1, 1'b1, 2'd1, 32'hCAFE0000, 32'h5AA50000, 32'hCAFE0000,
              32'h5AA50000, 16, 1'b0, 0);
        // Mode 1 and mode 2, single byte
        frame(1'b0, 1'b1, 1'b0, 2'd0, 32'h12345678, 32'h81000000, 32'h78000000,
              32'h00000081, 8, 1'b0, 0);
        frame(1'b1, 1'b0, 1'b0, 2'd0, 32'h9ABCDEF0, 32'h81000000, 32'hF0000000,
              32'h00000081, 8, 1'b0, 0);
        // Abort after 12 bits of a 4-byte frame, then a full big-endian frame
        frame(1'b0, 1'b0, 1'b0, 2'd3, 32'h55555555, 32'hFFFFFFFF, 32'h55550000,
              32'h00000081, 12, 1'b0, 0);
        frame(1'b0, 1'b0, 1'b1, 2'd3, 32'h01020304, 32'hDEADBEEF, 32'h01020304,
              32'hDEADBEEF, 32, 1'b0, 0);
        // Config changes mid-frame and extra clocks after completion
        frame(1'b0, 1'b0, 1'b0, 2'd1, 32'h0000C35A, 32'h3C960000, 32'h5AC30000,
              32'h0000963C, 16, 1'b1, 8);

        // Reset in the middle of a byte
        cfg_cpol  = 1'b0;
        cfg_cpha  = 1'b0;
        sspis_sck = 1'b0;
        #100;
        sspis_ssn  = 1'b0;
        sspis_mosi = 1'b1;
        #H sspis_sck = 1'b1;
        #H sspis_sck = 1'b0;
        #H sspis_sck = 1'b1;
        #20;
        reset = 1'b1;
        #10;
        chk_reset_outputs();
        reset     = 1'b0;
        sspis_sck = 1'b0;
        #100;
        chk("busy_after_reset_ssn_low", {31'd0, busy}, 32'd0);
        sspis_ssn = 1'b1;
        #100;
        frame(1'b0, 1'b0, 1'b0, 2'd0, 32'h000000E1, 32'hC7000000, 32'hE1000000,
              32'h000000C7, 8, 1'b0, 0);

        #100;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("frame_err_total", err_seen, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
